// File: rtl/id_reg_reader_if.sv
// Request/acknowledge register bus between the ID reader (master) and the
// register responder (slave). Single-beat reads; data is valid alongside ack.
interface id_reg_reader_if #(
  parameter int ADDR_W = 8
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [7:0]        rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data
  );
endinterface

// File: rtl/id_reg_reader.sv
// Chip-ID check requester: reads the ID register on start, compares it with
// EXPECTED_ID and retries on mismatch or timeout, reporting sticky status.
module id_reg_reader #(
  parameter logic [7:0]        EXPECTED_ID = 8'hA7,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] ID_ADDR     = '0,
  parameter int                TIMEOUT     = 16,
  parameter int                MAX_TRIES   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  id_reg_reader_if.master rd,
  output logic            busy,
  output logic            done,
  output logic            id_ok,
  output logic [7:0]      id_value,
  output logic            timeout_err,
  output logic [2:0]      tries
);

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0] TO_MAX    = 8'(TIMEOUT);
  localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EVAL = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [7:0] to_cnt;
  logic       timed_out;
  logic       match;

  // Single-cycle strobes from the next-state logic into the datapath.
  logic ld_start, take_ack, take_to, tick, retry, pass, fail;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ld_start   = 1'b0;
    take_ack   = 1'b0;
    take_to    = 1'b0;
    tick       = 1'b0;
    retry      = 1'b0;
    pass       = 1'b0;
    fail       = 1'b0;
    rd.rd_req  = 1'b0;
    rd.rd_addr = '0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          ld_start   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        rd.rd_req  = 1'b1;
        rd.rd_addr = ID_ADDR;
        // An ack on the final cycle of the window takes priority over timeout.
        if (rd.rd_ack) begin
          take_ack   = 1'b1;
          state_next = EVAL;
        end else if (to_cnt >= TO_LAST) begin
          take_to    = 1'b1;
          state_next = EVAL;
        end else begin
          tick = 1'b1;
        end
      end
      EVAL: begin
        if (match) begin
          pass       = 1'b1;
          state_next = FIN;
        end else if (tries < TRIES_MAX) begin
          retry      = 1'b1;
          state_next = REQ;
        end else begin
          fail       = 1'b1;
          state_next = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timed_out   <= 1'b0;
      match       <= 1'b0;
      id_ok       <= 1'b0;
      id_value    <= '0;
      timeout_err <= 1'b0;
      tries       <= '0;
    end else begin
      if (ld_start) begin
        id_ok       <= 1'b0;
        timeout_err <= 1'b0;
        tries       <= 3'd1;
        to_cnt      <= '0;
        timed_out   <= 1'b0;
        match       <= 1'b0;
      end
      if (tick) to_cnt <= to_cnt + 8'd1;
      if (take_to) begin
        // Counter parks at TIMEOUT until the next attempt clears it.
        to_cnt    <= TO_MAX;
        timed_out <= 1'b1;
        match     <= 1'b0;
      end
      if (take_ack) begin
        id_value  <= rd.rd_data;
        match     <= (rd.rd_data == EXPECTED_ID);
        timed_out <= 1'b0;
      end
      if (pass) id_ok <= 1'b1;
      if (retry) begin
        tries     <= tries + 3'd1;
        to_cnt    <= '0;
        timed_out <= 1'b0;
      end
      if (fail) begin
        id_ok       <= 1'b0;
        timeout_err <= timed_out;
      end
    end
  end

endmodule

// File: tb/tb_id_reg_reader.sv
// Directed bench for id_reg_reader: a cycle-level responder answers each
// request phase from a per-attempt table; scenario tasks check the outcome.
module tb_id_reg_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, id_ok, timeout_err;
  logic [7:0] id_value;
  logic [2:0] tries;

  id_reg_reader_if #(.ADDR_W(8)) bus ();

  id_reg_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rd          (bus),
    .busy        (busy),
    .done        (done),
    .id_ok       (id_ok),
    .id_value    (id_value),
    .timeout_err (timeout_err),
    .tries       (tries)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Responder table: REQ-phase cycle (0-based) on which to ack, -1 = never.
  int         resp_ack_at [3];
  logic [7:0] resp_data   [3];
  bit         stray_ack;

  // Observations from the last run.
  int         r_phases, r_min_gap, r_done_cnt, r_done_cyc, r_first_req;
  int         r_plen [3];
  bit         r_addr_ok, r_busy_ok, r_late_req;
  logic       r_ok_c1;
  logic [2:0] r_tries_c1;

  // Starts a check on the current cycle (cycle 0) and plays the responder
  // until a few cycles after DONE. Call just after a rising edge.
  task automatic run_check(input bit pulse_in_busy);
    int  plen, gap, idx, post;
    bit  in_phase, seen_done;
    plen = 0; gap = 0; idx = -1; post = 0; in_phase = 0; seen_done = 0;
    r_min_gap = 1000; r_done_cnt = 0; r_done_cyc = -1; r_first_req = -1;
    r_addr_ok = 1; r_busy_ok = 1; r_late_req = 0;
    for (int k = 0; k < 3; k++) r_plen[k] = 0;
    start = 1'b1;
    bus.rd_ack = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      start = pulse_in_busy && (cyc == 2 || cyc == 5 || done === 1'b1);
      if (cyc == 1) begin
        r_ok_c1    = id_ok;
        r_tries_c1 = tries;
      end
      if (busy !== !seen_done) r_busy_ok = 0;
      if (bus.rd_req === 1'b1) begin
        if (!in_phase) begin
          idx++;
          plen = 0;
          if (idx > 0 && gap < r_min_gap) r_min_gap = gap;
          if (seen_done) r_late_req = 1;
          if (r_first_req < 0) r_first_req = cyc;
        end
        in_phase = 1;
        gap = 0;
        plen++;
        if (idx < 3) r_plen[idx] = plen;
        if (bus.rd_addr !== 8'h00) r_addr_ok = 0;
        if (idx < 3 && resp_ack_at[idx] == plen - 1) begin
          bus.rd_ack  = 1'b1;
          bus.rd_data = resp_data[idx];
        end else begin
          bus.rd_ack  = 1'b0;
          bus.rd_data = 8'h33;
        end
      end else begin
        in_phase = 0;
        gap++;
        if (bus.rd_addr !== 8'h00) r_addr_ok = 0;
        bus.rd_ack  = stray_ack;
        bus.rd_data = 8'hA7;
      end
      if (done === 1'b1) begin
        r_done_cnt++;
        if (!seen_done) r_done_cyc = cyc;
        seen_done = 1;
      end
      if (seen_done) begin
        post++;
        if (post > 4) break;
      end
    end
    r_phases = idx + 1;
    start = 1'b0;
    bus.rd_ack = 1'b0;
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL run_budget: no DONE within 400 cycles");
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({bus.rd_req, busy, done, id_ok, timeout_err} !== 5'b0 ||
        bus.rd_addr !== 8'h00 || id_value !== 8'h00 || tries !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b busy=%b done=%b ok=%b terr=%b addr=%h val=%h tries=%0d, want all 0",
               bus.rd_req, busy, done, id_ok, timeout_err, bus.rd_addr, id_value, tries);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal(input string tag);
    resp_ack_at = '{0, -1, -1};
    resp_data   = '{8'hA7, 8'h00, 8'h00};
    stray_ack   = 0;
    run_check(0);
    checks++;
    if (r_first_req != 1 || r_phases != 1 || r_plen[0] != 1) begin
      failures++;
      $display("FAIL %s_req_shape: first=%0d phases=%0d len=%0d, want 1 1 1", tag, r_first_req, r_phases, r_plen[0]);
    end
    checks++;
    if (!r_addr_ok) begin
      failures++;
      $display("FAIL %s_addr: rd_addr not ID_ADDR during request / not 0 otherwise", tag);
    end
    checks++;
    if (r_done_cyc != 3 || r_done_cnt != 1) begin
      failures++;
      $display("FAIL %s_done: cycle=%0d count=%0d, want 3 1", tag, r_done_cyc, r_done_cnt);
    end
    checks++;
    if (!r_busy_ok) begin
      failures++;
      $display("FAIL %s_busy: busy not high exactly cycles 1..DONE", tag);
    end
    checks++;
    if (id_ok !== 1'b1 || id_value !== 8'hA7 || tries !== 3'd1 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_status: ok=%b val=%h tries=%0d terr=%b, want 1 a7 1 0", tag, id_ok, id_value, tries, timeout_err);
    end
  endtask

  task automatic test_retry_match();
    resp_ack_at = '{0, 0, -1};
    resp_data   = '{8'h5C, 8'hA7, 8'h00};
    stray_ack   = 0;
    run_check(0);
    checks++;
    if (r_ok_c1 !== 1'b0 || r_tries_c1 !== 3'd1) begin
      failures++;
      $display("FAIL retry_start_clear: ok=%b tries=%0d at cycle 1, want 0 1", r_ok_c1, r_tries_c1);
    end
    checks++;
    if (r_phases != 2 || r_min_gap < 1 || r_done_cyc != 5) begin
      failures++;
      $display("FAIL retry_shape: phases=%0d gap=%0d done=%0d, want 2 >=1 5", r_phases, r_min_gap, r_done_cyc);
    end
    checks++;
    if (id_ok !== 1'b1 || tries !== 3'd2 || id_value !== 8'hA7 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL retry_status: ok=%b tries=%0d val=%h terr=%b, want 1 2 a7 0", id_ok, tries, id_value, timeout_err);
    end
  endtask

  task automatic test_timeout();
    resp_ack_at = '{-1, -1, -1};
    resp_data   = '{8'h00, 8'h00, 8'h00};
    stray_ack   = 0;
    run_check(0);
    checks++;
    if (r_phases != 3 || r_plen[0] != 16 || r_plen[1] != 16 || r_plen[2] != 16) begin
      failures++;
      $display("FAIL timeout_phases: n=%0d len=%0d/%0d/%0d, want 3 16/16/16",
               r_phases, r_plen[0], r_plen[1], r_plen[2]);
    end
    checks++;
    if (r_done_cnt != 1 || r_done_cyc != 52 || r_min_gap < 1) begin
      failures++;
      $display("FAIL timeout_done: count=%0d cycle=%0d gap=%0d, want 1 52 >=1", r_done_cnt, r_done_cyc, r_min_gap);
    end
    checks++;
    if (id_ok !== 1'b0 || timeout_err !== 1'b1 || tries !== 3'd3 || id_value !== 8'hA7) begin
      failures++;
      $display("FAIL timeout_status: ok=%b terr=%b tries=%0d val=%h, want 0 1 3 a7", id_ok, timeout_err, tries, id_value);
    end
  endtask

  task automatic test_wrong_data();
    resp_ack_at = '{0, 0, 0};
    resp_data   = '{8'h00, 8'hFF, 8'hA6};
    stray_ack   = 1;
    run_check(0);
    checks++;
    if (r_phases != 3 || r_done_cnt != 1 || r_done_cyc != 7) begin
      failures++;
      $display("FAIL wrong_shape: phases=%0d dones=%0d cycle=%0d, want 3 1 7", r_phases, r_done_cnt, r_done_cyc);
    end
    checks++;
    if (id_ok !== 1'b0 || timeout_err !== 1'b0 || tries !== 3'd3 || id_value !== 8'hA6) begin
      failures++;
      $display("FAIL wrong_status: ok=%b terr=%b tries=%0d val=%h, want 0 0 3 a6", id_ok, timeout_err, tries, id_value);
    end
  endtask

  task automatic test_ack_at_timeout();
    resp_ack_at = '{15, -1, -1};
    resp_data   = '{8'hA7, 8'h00, 8'h00};
    stray_ack   = 0;
    run_check(1);
    checks++;
    if (r_phases != 1 || r_plen[0] != 16 || r_done_cyc != 18) begin
      failures++;
      $display("FAIL edge_shape: phases=%0d len=%0d done=%0d, want 1 16 18", r_phases, r_plen[0], r_done_cyc);
    end
    checks++;
    if (r_done_cnt != 1 || r_late_req) begin
      failures++;
      $display("FAIL edge_busy_start: dones=%0d late_req=%b, want 1 0", r_done_cnt, r_late_req);
    end
    checks++;
    if (id_ok !== 1'b1 || tries !== 3'd1 || timeout_err !== 1'b0 || id_value !== 8'hA7) begin
      failures++;
      $display("FAIL edge_status: ok=%b tries=%0d terr=%b val=%h, want 1 1 0 a7", id_ok, tries, timeout_err, id_value);
    end
  endtask

  task automatic test_reset_mid_txn();
    bit quiet;
    start = 1'b1;
    bus.rd_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (bus.rd_req !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: rd_req=%b, want 1", bus.rd_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rd_req, busy, done, id_ok, timeout_err} !== 5'b0 ||
        bus.rd_addr !== 8'h00 || id_value !== 8'h00 || tries !== 3'd0) begin
      failures++;
      $display("FAIL midrst_async: req=%b busy=%b done=%b ok=%b terr=%b addr=%h val=%h tries=%0d, want all 0",
               bus.rd_req, busy, done, id_ok, timeout_err, bus.rd_addr, id_value, tries);
    end
    quiet = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || bus.rd_req !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL midrst_hold: done/busy/rd_req active while in reset");
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_nominal("after_rst");
  endtask

  initial begin
    bus.rd_ack  = 1'b0;
    bus.rd_data = 8'h00;
    stray_ack   = 0;
    test_reset();
    test_nominal("nominal");
    test_retry_match();
    test_timeout();
    test_wrong_data();
    test_ack_at_timeout();
    test_reset_mid_txn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_reg_reader.md
Name: id_reg_reader

Overview:
- Requester side of the chip-ID register interface. On a START pulse, it issues a single-beat read of the ID register over the simple request/acknowledge register bus.
- Compares the returned byte against the expected chip ID, retrying on mismatch or timeout. Reports pass/fail, the captured value and the attempt count.
- Sits on the host/debug side and is used by bring-up logic to confirm the SIMD-DLX core is present before the core is released.

Parameters:
- EXPECTED_ID, 8'hA7, value ID_OK compares against.
- ADDR_W, 8, register bus address width.
- ID_ADDR, 0, address placed on RD_ADDR during every attempt.
- TIMEOUT, 16, cycles RD_REQ may stay high without RD_ACK before the attempt is aborted (1..255).
- MAX_TRIES, 3, total attempts before failing (1..7).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle request to run a check; ignored while BUSY=1
- RD_REQ  out  1  read request, level, held until acknowledged or timed out
- RD_ADDR  out  ADDR_W  ID_ADDR while RD_REQ=1, else 0
- RD_ACK  in  1  responder acknowledge; RD_DATA valid in same cycle
- RD_DATA  in  8  read data
- BUSY  out  1  high from the cycle after START until the DONE cycle, inclusive
- DONE  out  1  one-cycle completion pulse
- ID_OK  out  1  sticky: last check matched EXPECTED_ID
- ID_VALUE  out  8  sticky: last byte captured on an acknowledged read
- TIMEOUT_ERR  out  1  sticky: last check failed with final attempt timed out
- TRIES  out  3  sticky: attempts used by last check (1..MAX_TRIES)

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0: RD_REQ, RD_ADDR, BUSY, DONE, ID_OK, ID_VALUE, TIMEOUT_ERR, TRIES.
  - Internal timeout and attempt counters 0.
- State IDLE:
  - START=1 moves to REQ.
  - On that edge: clear ID_OK and TIMEOUT_ERR, set TRIES=1, clear the timeout counter.
  - ID_VALUE keeps its old value until the next acknowledged read.
- State REQ:
  - RD_REQ=1 and RD_ADDR=ID_ADDR. Timeout counter increments every cycle RD_ACK=0.
  - RD_REQ=1 with RD_ACK=1 completes the transaction in that cycle. RD_ACK while not in REQ is ignored.
  - On ack: capture RD_DATA into ID_VALUE and go to EVAL. The compare result is registered as match = (RD_DATA == EXPECTED_ID).
  - If the counter reaches TIMEOUT with no ack: drop RD_REQ, mark the attempt timed out, go to EVAL.
  - Ack and timeout in the same cycle: the ack wins.
- State EVAL (1 cycle, RD_REQ=0):
  - If match: ID_OK=1, go to FIN.
  - Else if TRIES < MAX_TRIES: TRIES+1, clear the timeout counter, go to REQ. This guarantees at least one idle cycle with RD_REQ low between attempts.
  - Else: ID_OK=0, TIMEOUT_ERR = the last attempt's timeout flag, go to FIN.
- State FIN: DONE=1 for exactly one cycle, then IDLE. BUSY is 1 in REQ, EVAL and FIN.
- START handling:
  - START in IDLE during the FIN→IDLE transition cycle is not seen. START is only sampled in IDLE.
  - START while BUSY is dropped, not queued.
- Nominal latency, START at cycle 0 with ack at the first request cycle:
  - RD_REQ high in cycle 1.
  - EVAL in cycle 2.
  - DONE in cycle 3.
- Reset mid-transaction: RD_REQ drops immediately (async), with no DONE pulse. The responder must tolerate request withdrawal.
- Counter widths: the timeout counter is 8 bits and saturates at TIMEOUT; TRIES is 3 bits.

Test Plan:
1. Reset then START, responder acks on first REQ cycle with RD_DATA=8'hA7:
   - RD_REQ high cycle 1 only, RD_ADDR=ID_ADDR.
   - DONE cycle 3, ID_OK=1, ID_VALUE=8'hA7, TRIES=1, TIMEOUT_ERR=0.
2. Responder returns 8'h5C then 8'hA7:
   - Two REQ phases separated by ≥1 low cycle.
   - ID_OK=1, TRIES=2, ID_VALUE=8'hA7.
3. Responder never acks (TIMEOUT=16, MAX_TRIES=3):
   - Three REQ phases each exactly 16 cycles.
   - DONE once, ID_OK=0, TIMEOUT_ERR=1, TRIES=3, ID_VALUE unchanged from before.
4. Wrong data all three tries (8'h00, 8'hFF, 8'hA6):
   - ID_OK=0, TIMEOUT_ERR=0, TRIES=3, ID_VALUE=8'hA6.
5. Ack lands on the cycle the counter hits TIMEOUT with data 8'hA7:
   - Ack wins, ID_OK=1, TRIES=1.
   - START pulsed during BUSY has no effect: exactly one DONE.
6. RST_N asserted while RD_REQ=1:
   - RD_REQ, BUSY and all sticky outputs go 0 asynchronously, no DONE.
   - After release, a fresh START completes normally as in scenario 1.
